// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetches a 16-bit word, drives the ALU and
// register-file read ports, then writes back and advances or redirects pc.
module instr_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    output logic        fetch_req,
    output logic [15:0] pc,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic [2:0]  rd_addr_a,
    output logic [2:0]  rd_addr_b,
    input  logic [15:0] rd_data_a,
    output logic [4:0]  alu_op,
    input  logic [15:0] alu_result,
    input  logic        flag_gt,
    input  logic        flag_lt,
    input  logic        flag_eq,
    output logic        wr_en,
    output logic [2:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        halted,
    input  logic        resume,
    output logic [15:0] retired
);

    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_ADC  = 5'd2;
    localparam logic [4:0] OP_SUB  = 5'd3;
    localparam logic [4:0] OP_SDC  = 5'd4;
    localparam logic [4:0] OP_SBB  = 5'd5;
    localparam logic [4:0] OP_AND  = 5'd6;
    localparam logic [4:0] OP_OR   = 5'd7;
    localparam logic [4:0] OP_XOR  = 5'd8;
    localparam logic [4:0] OP_NOT  = 5'd9;
    localparam logic [4:0] OP_SHFT = 5'd10;
    localparam logic [4:0] OP_MOV  = 5'd11;
    localparam logic [4:0] OP_JMP  = 5'd12;
    localparam logic [4:0] OP_JGO  = 5'd13;
    localparam logic [4:0] OP_JLO  = 5'd14;
    localparam logic [4:0] OP_JEO  = 5'd15;
    localparam logic [4:0] OP_HLT  = 5'd16;
    localparam logic [4:0] OP_RST  = 5'd17;
    localparam logic [4:0] OP_SETH = 5'd18;
    localparam logic [4:0] OP_SETL = 5'd19;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        WB,
        HALT
    } state_t;

    state_t      state, state_d;
    logic [15:0] ir;
    logic [15:0] alu_q;
    logic [15:0] rda_q;
    logic        gt_q, lt_q, eq_q;
    logic [15:0] pc_wb;
    logic [4:0]  op;
    logic [15:0] pc_inc;

    assign op     = ir[15:11];
    assign pc_inc = pc + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = FETCH;
            FETCH:   if (instr_valid) state_d = EXEC;
            EXEC:    state_d = (op == OP_HLT) ? HALT : WB;
            WB:      state_d = FETCH;
            HALT:    if (resume) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fetch_req = (state == FETCH);
        halted    = (state == HALT);
        rd_addr_a = ir[10:8];
        rd_addr_b = '0;
        alu_op    = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        if (state == EXEC) begin
            rd_addr_b = ir[7:5];
            alu_op    = op;
        end
        if (state == WB) begin
            case (op)
                OP_ADD, OP_ADC, OP_SUB, OP_SDC, OP_SBB,
                OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHFT: begin
                    wr_en   = 1'b1;
                    wr_addr = ir[4:2];
                    wr_data = alu_q;
                end
                OP_MOV: begin
                    wr_en   = 1'b1;
                    wr_addr = ir[4:2];
                    wr_data = rda_q;
                end
                OP_SETH: begin
                    wr_en   = 1'b1;
                    wr_addr = ir[10:8];
                    wr_data = {ir[7:0], rda_q[7:0]};
                end
                OP_SETL: begin
                    wr_en   = 1'b1;
                    wr_addr = ir[10:8];
                    wr_data = {rda_q[15:8], ir[7:0]};
                end
                default: ;
            endcase
        end
    end

    // Branch decisions use the flags captured at the end of EXEC, not the live ones
    always_comb begin
        pc_wb = pc_inc;
        case (op)
            OP_JMP:  pc_wb = rda_q;
            OP_JGO:  pc_wb = gt_q ? rda_q : pc_inc;
            OP_JLO:  pc_wb = lt_q ? rda_q : pc_inc;
            OP_JEO:  pc_wb = eq_q ? rda_q : pc_inc;
            OP_RST:  pc_wb = '0;
            default: pc_wb = pc_inc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= '0;
            ir      <= '0;
            retired <= '0;
            alu_q   <= '0;
            rda_q   <= '0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            case (state)
                FETCH: if (instr_valid) ir <= instr;
                EXEC: begin
                    alu_q <= alu_result;
                    rda_q <= rd_data_a;
                    gt_q  <= flag_gt;
                    lt_q  <= flag_lt;
                    eq_q  <= flag_eq;
                    if (op == OP_HLT) retired <= retired + 16'd1;
                end
                WB: begin
                    pc      <= pc_wb;
                    retired <= retired + 16'd1;
                end
                HALT: if (resume) pc <= pc_inc;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: an instruction-level model sets per-cycle
// expectations that one negedge process compares against the DUT.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic [15:0] pc;
    logic        instr_valid;
    logic [15:0] instr;
    logic [2:0]  rd_addr_a, rd_addr_b;
    logic [15:0] rd_data_a;
    logic [4:0]  alu_op;
    logic [15:0] alu_result;
    logic        flag_gt, flag_lt, flag_eq;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        halted;
    logic        resume;
    logic [15:0] retired;

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .pc(pc),
        .instr_valid(instr_valid), .instr(instr),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a),
        .alu_op(alu_op), .alu_result(alu_result),
        .flag_gt(flag_gt), .flag_lt(flag_lt), .flag_eq(flag_eq),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .halted(halted), .resume(resume), .retired(retired)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Architectural model state
    logic [15:0] m_pc, m_ret, m_ir;

    // Per-cycle expectations
    bit          chk_en = 1'b0;
    logic        e_fetch, e_halted, e_wr_en;
    logic [2:0]  e_wr_addr, e_rda, e_rdb;
    bit          e_chk_rdb;
    logic [4:0]  e_alu_op;
    logic [15:0] e_wr_data, e_pc, e_retired;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("fetch_req", 16'(fetch_req), 16'(e_fetch));
            chk("halted",    16'(halted),    16'(e_halted));
            chk("pc",        pc,             e_pc);
            chk("retired",   retired,        e_retired);
            chk("alu_op",    16'(alu_op),    16'(e_alu_op));
            chk("rd_addr_a", 16'(rd_addr_a), 16'(e_rda));
            chk("wr_en",     16'(wr_en),     16'(e_wr_en));
            chk("wr_addr",   16'(wr_addr),   16'(e_wr_addr));
            chk("wr_data",   wr_data,        e_wr_data);
            if (e_chk_rdb) chk("rd_addr_b", 16'(rd_addr_b), 16'(e_rdb));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_base(input logic f, input logic h, input logic [4:0] aop);
        e_fetch   = f;
        e_halted  = h;
        e_alu_op  = aop;
        e_pc      = m_pc;
        e_retired = m_ret;
        e_rda     = m_ir[10:8];
        e_wr_en   = 1'b0;
        e_wr_addr = '0;
        e_wr_data = '0;
        e_chk_rdb = 1'b0;
        e_rdb     = '0;
    endtask

    // Effect of one instruction, straight from the ISA table
    task automatic model_effect(input logic [15:0] w, input logic [15:0] rda, input logic [15:0] alu,
                                input logic gt, input logic lt, input logic eq,
                                output logic we, output logic [2:0] wa, output logic [15:0] wd,
                                output logic [15:0] npc);
        int unsigned opc;
        opc = w[15:11];
        we = 1'b0; wa = '0; wd = '0;
        npc = m_pc + 16'd1;
        if (opc >= 1 && opc <= 10) begin we = 1'b1; wa = w[4:2]; wd = alu; end
        else if (opc == 11) begin we = 1'b1; wa = w[4:2]; wd = rda; end
        else if (opc == 18) begin we = 1'b1; wa = w[10:8]; wd = {w[7:0], rda[7:0]}; end
        else if (opc == 19) begin we = 1'b1; wa = w[10:8]; wd = {rda[15:8], w[7:0]}; end
        if (opc == 12) npc = rda;
        else if (opc == 13 && gt) npc = rda;
        else if (opc == 14 && lt) npc = rda;
        else if (opc == 15 && eq) npc = rda;
        else if (opc == 17) npc = '0;
    endtask

    logic        last_we;
    logic [2:0]  last_wa;
    logic [15:0] last_wd, last_pc;
    int          last_cycles;

    task automatic do_reset_release();
        m_pc = '0; m_ret = '0; m_ir = '0;
        expect_base(1'b0, 1'b0, 5'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
    endtask

    task automatic run_instr(input logic [15:0] w, input logic [15:0] rda, input logic [15:0] alu,
                             input logic gt, input logic lt, input logic eq,
                             input int waits, input int halt_cycles, input bit abort_wb);
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd, npc;
        last_cycles = 0;
        resume = 1'b0;
        for (int i = 0; i < waits; i++) begin
            instr_valid = 1'b0;
            instr = 16'($urandom);
            expect_base(1'b1, 1'b0, 5'd0);
            step(); last_cycles++;
        end
        instr_valid = 1'b1;
        instr = w;
        expect_base(1'b1, 1'b0, 5'd0);
        step(); last_cycles++;
        m_ir = w;
        instr = 16'h8000;
        rd_data_a = rda; alu_result = alu;
        flag_gt = gt; flag_lt = lt; flag_eq = eq;
        resume = 1'b1;
        expect_base(1'b0, 1'b0, w[15:11]);
        e_chk_rdb = 1'b1;
        e_rdb = w[7:5];
        step(); last_cycles++;
        model_effect(w, rda, alu, gt, lt, eq, we, wa, wd, npc);
        if (w[15:11] == 5'd16) begin
            m_ret = m_ret + 16'd1;
            resume = 1'b0;
            expect_base(1'b0, 1'b1, 5'd0);
            for (int i = 0; i < halt_cycles; i++) step();
            resume = 1'b1;
            step();
            resume = 1'b0;
            m_pc = m_pc + 16'd1;
            last_pc = pc;
        end else begin
            last_we = wr_en; last_wa = wr_addr; last_wd = wr_data;
            rd_data_a = ~rda; alu_result = ~alu;
            flag_gt = ~gt; flag_lt = ~lt; flag_eq = ~eq;
            if (abort_wb) begin
                rst_n = 1'b0;
                resume = 1'b0;
                #1;
                chk("abort_wr_en", 16'(wr_en), 16'h0);
                chk("abort_pc", pc, 16'h0000);
                chk("abort_fetch", 16'(fetch_req), 16'h0);
                do_reset_release();
                return;
            end
            expect_base(1'b0, 1'b0, 5'd0);
            e_wr_en = we; e_wr_addr = wa; e_wr_data = wd;
            step(); last_cycles++;
            resume = 1'b0;
            m_pc = npc;
            m_ret = m_ret + 16'd1;
            last_pc = pc;
        end
        instr_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        instr_valid = 1'b0; instr = '0; rd_data_a = '0; alu_result = '0;
        flag_gt = 1'b0; flag_lt = 1'b0; flag_eq = 1'b0; resume = 1'b0;
        #1;
        chk("reset_pc", pc, 16'h0000);
        chk("reset_retired", retired, 16'h0000);
        chk("reset_wr_en", 16'(wr_en), 16'h0);
        m_pc = '0; m_ret = '0; m_ir = '0;
        expect_base(1'b0, 1'b0, 5'd0);
        chk_en = 1'b1;
        step();
        do_reset_release();

        // ADD R1=1 R2=2 QR=3
        run_instr(16'h094C, 16'h1111, 16'h0042, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        chk("add_we", 16'(last_we), 16'h1);
        chk("add_wa", 16'(last_wa), 16'h3);
        chk("add_wd", last_wd, 16'h0042);
        chk("add_pc", last_pc, 16'h0001);
        chk("add_retired", retired, 16'h0001);
        chk("add_cycles", 16'(last_cycles), 16'd3);

        run_instr(16'h95AB, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        chk("seth_wd", last_wd, 16'hAB34);
        chk("seth_wa", 16'(last_wa), 16'h5);
        run_instr(16'h9DCD, 16'hAB34, 16'h0000, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        chk("setl_wd", last_wd, 16'hABCD);

        run_instr(16'h7800, 16'h0100, 16'h5555, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
        chk("jeo_taken_pc", last_pc, 16'h0100);
        chk("jeo_taken_we", 16'(last_we), 16'h0);
        run_instr(16'h7800, 16'h0100, 16'h5555, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
        chk("jeo_not_pc", last_pc, 16'h0101);

        run_instr(16'h094C, 16'h0000, 16'h7777, 1'b0, 1'b0, 1'b0, 4, 0, 1'b0);
        chk("wait_cycles", 16'(last_cycles), 16'd7);
        chk("wait_pc", last_pc, 16'h0102);

        run_instr(16'h5A18, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0);
        chk("mov_wd", last_wd, 16'hBEEF);
        run_instr(16'h1A7C, 16'h0003, 16'hFFFE, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr(16'h6800, 16'h0200, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        chk("jgo_pc", last_pc, 16'h0200);
        run_instr(16'h7000, 16'h0300, 16'h0000, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
        chk("jlo_not_pc", last_pc, 16'h0201);
        run_instr(16'hCFFF, 16'h4444, 16'h9999, 1'b1, 1'b1, 1'b1, 2, 0, 1'b0);
        chk("reserved_we", 16'(last_we), 16'h0);
        run_instr(16'h8800, 16'h4444, 16'h0000, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        chk("rst_pc", last_pc, 16'h0000);

        run_instr(16'h6000, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr(16'h8000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 0, 5, 1'b0);
        chk("hlt_resume_pc", last_pc, 16'h0011);
        chk("hlt_resume_fetch", 16'(fetch_req), 16'h1);

        run_instr(16'h6000, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr(16'h0000, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        chk("wrap_pc", last_pc, 16'h0000);

        run_instr(16'h094C, 16'h0001, 16'h00AA, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        chk("post_abort_retired", retired, 16'h0000);
        run_instr(16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        chk("post_abort_pc", last_pc, 16'h0001);

        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 Ports SHALL be:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- fetch_req  out  1  instruction fetch request
- pc  out  16  fetch address
- instr_valid  in  1  instr holds the word for pc this cycle
- instr  in  16  {op[15:11], R1[10:8], R2[7:5], QR[4:2], RES[1:0]}
- rd_addr_a  out  3  register-file read port A address
- rd_addr_b  out  3  register-file read port B address
- rd_data_a  in  16  register-file read port A data
- alu_op  out  5  opcode presented to the ALU
- alu_result  in  16  ALU result
- flag_gt, flag_lt, flag_eq  in  1 each  ALU compare flags
- wr_en  out  1  register write strobe
- wr_addr  out  3  register write address
- wr_data  out  16  register write data
- halted  out  1  core halted
- resume  in  1  leave HALT
- retired  out  16  retired-instruction count

Function
REQ-003 Opcodes: 0 NOP, 1 ADD, 2 ADC, 3 SUB, 4 SDC, 5 SBB, 6 AND, 7 OR, 8 XOR, 9 NOT, 10 SHFT, 11 MOV, 12 JMP, 13 JGO, 14 JLO, 15 JEO, 16 HLT, 17 RST, 18 SETH, 19 SETL; 20-31 SHALL execute as NOP.
REQ-004 FSM states SHALL be IDLE, FETCH, EXEC, WB, HALT; IDLE->FETCH unconditionally.
REQ-005 fetch_req SHALL be 1 exactly while in FETCH; FETCH SHALL hold (pc stable) until instr_valid=1, then latch instr into IR and go to EXEC.
REQ-006 In EXEC: rd_addr_a=IR.R1, rd_addr_b=IR.R2, alu_op=IR.op. alu_result, rd_data_a and the flags SHALL be registered at the end of EXEC. Outside EXEC, alu_op=0 and rd_addr_a=IR.R1.
REQ-007 EXEC SHALL go to HALT for HLT and to WB for all other opcodes.
REQ-008 WB SHALL last one cycle and then go to FETCH.
- Opcodes 1-10: wr_en=1, wr_addr=QR, wr_data=alu_result.
- MOV: wr_en=1, wr_addr=QR, wr_data=rd_data_a.
- SETH: wr_en=1, wr_addr=R1, wr_data={IR[7:0], rd_data_a[7:0]}.
- SETL: wr_en=1, wr_addr=R1, wr_data={rd_data_a[15:8], IR[7:0]}.
- All other opcodes: wr_en=0.
REQ-009 wr_en SHALL be 0 in every state other than WB; while wr_en=0, wr_addr and wr_data SHALL be 0.
REQ-010 PC update in WB:
- JMP: pc<=rd_data_a.
- JGO, JLO, JEO: pc<=rd_data_a if the registered flag_gt, flag_lt or flag_eq (respectively) is 1, else pc+1.
- RST: pc<=0.
- All others: pc<=pc+1, wrapping 16'hFFFF->16'h0000.
REQ-011 Minimum latency SHALL be 3 cycles per instruction (FETCH, EXEC, WB) with instr_valid=1 on the first FETCH cycle; each FETCH wait cycle adds exactly 1.
REQ-012 HALT: halted=1 and pc is held at the HLT address. resume=1 SHALL set pc<=pc+1 and go to FETCH. halted SHALL be 0 in all other states.
REQ-013 retired SHALL increment (modulo 2^16) on leaving WB and on entering HALT, including for NOP, RST and reserved opcodes.
REQ-014 instr_valid and instr SHALL be ignored outside FETCH; resume SHALL be ignored outside HALT.

Reset
REQ-015 rst_n=0 SHALL immediately force: state IDLE, pc=0, IR=0, retired=0, fetch_req=0, wr_en=0, wr_addr=0, wr_data=0, alu_op=0, rd_addr_a=0, rd_addr_b=0, halted=0.
REQ-016 Reset asserted mid-instruction (any state) SHALL abort the instruction with no write. The first fetch_req SHALL occur on the second rising edge after rst_n deasserts.

Verification
REQ-017 Reset release, instr_valid tied 1, ADD R1=1 R2=2 QR=3 at pc 0, alu_result=16'h0042 -> wr_en=1, wr_addr=3, wr_data=16'h0042 in the 3rd cycle; pc=1; retired=1.
REQ-018 SETH R1=5 imm 8'hAB with rd_data_a=16'h1234 -> wr_data=16'hAB34, wr_addr=5; then SETL imm 8'hCD with rd_data_a=16'hAB34 -> wr_data=16'hABCD.
REQ-019 JEO with rd_data_a=16'h0100: flag_eq=1 -> pc=16'h0100 and wr_en=0; flag_eq=0 -> pc=old pc+1.
REQ-020 instr_valid held low 4 cycles in FETCH -> fetch_req stays 1 and pc stable; the instruction completes in 7 cycles.
REQ-021 HLT at pc 16'h0010 -> halted=1 and pc=16'h0010 indefinitely; resume pulse -> pc=16'h0011, fetch_req=1 next cycle.
REQ-022 pc=16'hFFFF executing NOP -> pc=0. rst_n pulsed low during WB of an ADD -> no wr_en, pc=0.
